// File: rtl/sdram_arbiter_if.sv
// Requester and SDRAM-controller signal bundle for sdram_arbiter.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface sdram_arbiter_if;
  logic        vid_req;
  logic [22:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_data;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [22:0] cpu_addr;
  logic [1:0]  cpu_bank;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_wait;
  logic        ldr_wr;
  logic [22:0] ldr_addr;
  logic [1:0]  ldr_bank;
  logic [7:0]  ldr_din;
  logic        ldr_busy;
  logic        ldr_overrun;
  logic        mem_req;
  logic        mem_we;
  logic [22:0] mem_addr;
  logic [1:0]  mem_bank;
  logic [7:0]  mem_din;
  logic        mem_ack;
  logic [15:0] mem_dout;
  logic        err;

  modport slave (
    input  vid_req, vid_addr, cpu_rd, cpu_wr, cpu_addr, cpu_bank, cpu_din,
           ldr_wr, ldr_addr, ldr_bank, ldr_din, mem_ack, mem_dout,
    output vid_ack, vid_data, cpu_dout, cpu_wait, ldr_busy, ldr_overrun,
           mem_req, mem_we, mem_addr, mem_bank, mem_din, err
  );

  modport master (
    output vid_req, vid_addr, cpu_rd, cpu_wr, cpu_addr, cpu_bank, cpu_din,
           ldr_wr, ldr_addr, ldr_bank, ldr_din, mem_ack, mem_dout,
    input  vid_ack, vid_data, cpu_dout, cpu_wait, ldr_busy, ldr_overrun,
           mem_req, mem_we, mem_addr, mem_bank, mem_din, err
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Fixed-priority SDRAM channel arbiter (video > CPU > loader) with loader
// starvation override and an acknowledge watchdog.
module sdram_arbiter #(
  parameter int unsigned STARVE_MAX = 15,
  parameter int unsigned TIMEOUT    = 63
) (
  input logic            clk_sys,
  input logic            reset_n,
  sdram_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {W_NONE, W_VID, W_CPU, W_LDR} src_t;

  state_t      state_q;
  src_t        gnt_q, win;
  logic        mem_req_q, mem_we_q;
  logic [22:0] mem_addr_q;
  logic [1:0]  mem_bank_q;
  logic [7:0]  mem_din_q;
  logic        vid_ack_q;
  logic [15:0] vid_data_q;
  logic [7:0]  cpu_dout_q;
  logic        cpu_done_q;
  logic        ldr_full_q, ldr_ovr_q;
  logic [22:0] ldr_addr_q;
  logic [1:0]  ldr_bank_q;
  logic [7:0]  ldr_din_q;
  logic [7:0]  starve_q, wd_q;
  logic        err_q;

  logic cpu_req, cpu_pend, ack_now, ldr_free, force_ldr;

  assign cpu_req   = bus.cpu_rd | bus.cpu_wr;
  assign cpu_pend  = cpu_req & ~cpu_done_q;
  assign ack_now   = (state_q == BUSY) & bus.mem_ack;
  assign ldr_free  = ack_now & (gnt_q == W_LDR);
  assign force_ldr = ldr_full_q & (starve_q == 8'(STARVE_MAX));

  always_comb begin
    win = W_NONE;
    if (force_ldr)          win = W_LDR;
    else if (bus.vid_req)   win = W_VID;
    else if (cpu_pend)      win = W_CPU;
    else if (ldr_full_q)    win = W_LDR;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt_q      <= W_NONE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_bank_q <= '0;
      mem_din_q  <= '0;
      vid_ack_q  <= 1'b0;
      vid_data_q <= '0;
      cpu_dout_q <= '0;
      cpu_done_q <= 1'b0;
      ldr_full_q <= 1'b0;
      ldr_ovr_q  <= 1'b0;
      ldr_addr_q <= '0;
      ldr_bank_q <= '0;
      ldr_din_q  <= '0;
      starve_q   <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      vid_ack_q <= 1'b0;
      err_q     <= 1'b0;
      if (!cpu_req) cpu_done_q <= 1'b0;

      // A strobe landing on the cycle the buffer drains refills it.
      if (bus.ldr_wr && (!ldr_full_q || ldr_free)) begin
        ldr_full_q <= 1'b1;
        ldr_addr_q <= bus.ldr_addr;
        ldr_bank_q <= bus.ldr_bank;
        ldr_din_q  <= bus.ldr_din;
      end else begin
        if (ldr_free)   ldr_full_q <= 1'b0;
        if (bus.ldr_wr) ldr_ovr_q  <= 1'b1;
      end

      if (!ldr_full_q) starve_q <= '0;
      else if (state_q == IDLE) begin
        if (win == W_LDR)            starve_q <= '0;
        else if (starve_q != 8'hFF)  starve_q <= starve_q + 8'd1;
      end

      case (state_q)
        IDLE: if (win != W_NONE) begin
          state_q   <= BUSY;
          gnt_q     <= win;
          mem_req_q <= 1'b1;
          wd_q      <= '0;
          case (win)
            W_VID: begin
              mem_we_q <= 1'b0; mem_addr_q <= bus.vid_addr;
              mem_bank_q <= 2'd0; mem_din_q <= 8'd0;
            end
            W_CPU: begin
              mem_we_q <= bus.cpu_wr; mem_addr_q <= bus.cpu_addr;
              mem_bank_q <= bus.cpu_bank; mem_din_q <= bus.cpu_din;
            end
            default: begin
              mem_we_q <= 1'b1; mem_addr_q <= ldr_addr_q;
              mem_bank_q <= ldr_bank_q; mem_din_q <= ldr_din_q;
            end
          endcase
        end
        BUSY: if (bus.mem_ack) begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          if (gnt_q == W_VID) begin
            vid_data_q <= bus.mem_dout;
            vid_ack_q  <= 1'b1;
          end
          if (gnt_q == W_CPU) begin
            if (cpu_req) cpu_done_q <= 1'b1;
            if (!mem_we_q)
              cpu_dout_q <= mem_addr_q[0] ? bus.mem_dout[15:8] : bus.mem_dout[7:0];
          end
        end else if (wd_q == 8'(TIMEOUT - 1)) begin
          // Abandon the grant; the loader entry stays buffered for a retry.
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          err_q     <= 1'b1;
        end else begin
          wd_q <= wd_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_bank    = mem_bank_q;
  assign bus.mem_din     = mem_din_q;
  assign bus.vid_ack     = vid_ack_q;
  assign bus.vid_data    = vid_data_q;
  assign bus.cpu_dout    = cpu_dout_q;
  assign bus.cpu_wait    = cpu_pend;
  assign bus.ldr_busy    = ldr_full_q;
  assign bus.ldr_overrun = ldr_ovr_q;
  assign bus.err         = err_q;
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM channel between three requesters: video fetch (16-bit words), Z80 CPU (byte read/write) and the ROM/expansion loader (byte write stream).
- Sits between the motherboard/loader logic and the sdram controller, replacing ad-hoc reset-time muxing of boot and CPU addresses.
- Serialises accesses with a fixed-priority scheme, with starvation protection for the loader and a watchdog for lost acknowledges.

Parameters:
- STARVE_MAX, 15: consecutive lost arbitrations after which the pending loader write is force-granted (1..255).
- TIMEOUT, 63: clk_sys cycles to wait for mem_ack before a grant is aborted (1..255).

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  video word request (level, held until vid_ack).
- vid_addr  in  23  video word address.
- vid_ack  out  1  one-cycle pulse; vid_data valid in the same cycle.
- vid_data  out  16  registered video word.
- cpu_rd  in  1  CPU read request (level).
- cpu_wr  in  1  CPU write request (level).
- cpu_addr  in  23  CPU byte address.
- cpu_bank  in  2  SDRAM bank for CPU accesses.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  latched CPU read byte.
- cpu_wait  out  1  high while a CPU request is pending and not yet served.
- ldr_wr  in  1  loader write strobe (one-cycle pulse).
- ldr_addr  in  23  loader byte address.
- ldr_bank  in  2  loader bank.
- ldr_din  in  8  loader data.
- ldr_busy  out  1  high while the loader buffer is full.
- ldr_overrun  out  1  sticky: a loader strobe arrived while the buffer was full.
- mem_req  out  1  request to the sdram controller, held until mem_ack.
- mem_we  out  1  write enable for the current grant.
- mem_addr  out  23  address for the current grant.
- mem_bank  out  2  bank for the current grant.
- mem_din  out  8  write data for the current grant.
- mem_ack  in  1  one-cycle completion pulse from the controller.
- mem_dout  in  16  read word, valid with mem_ack.
- err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0, except cpu_wait, which is combinational from the current request. Loader buffer empty, starve counter 0, watchdog 0, ldr_overrun 0.
- Loader buffer:
  - ldr_wr with the buffer empty captures addr/bank/din, then ldr_busy=1 from the next cycle.
  - ldr_wr with the buffer full is dropped and sets ldr_overrun until reset.
  - The buffer empties on its mem_ack. If the buffer frees and ldr_wr arrives in the same cycle, the new write is captured.
- CPU pending = (cpu_rd|cpu_wr) & ~cpu_done.
  - cpu_done is set on the CPU mem_ack and cleared when cpu_rd and cpu_wr are both low.
  - cpu_wait = pending (combinational).
  - cpu_rd and cpu_wr both high is treated as a write.
- State IDLE picks a winner each cycle. Priority: video > CPU > loader.
  - Exception: when starve_cnt==STARVE_MAX and the loader buffer is full, the loader wins.
  - The winner's fields are registered onto mem_*, mem_req=1 next cycle, state BUSY.
- starve_cnt: +1 (saturating) each IDLE arbitration in which the loader is full but loses. Cleared when the loader is granted or its buffer is empty.
- State BUSY:
  - mem_req and mem_* are held stable until mem_ack.
  - On mem_ack: mem_req=0 and the state returns to IDLE in the next cycle. A new grant can therefore assert mem_req 2 cycles after mem_ack at the earliest.
  - Video grant ack: vid_data<=mem_dout and vid_ack pulses 1 cycle after mem_ack.
  - CPU read ack: cpu_dout<=cpu_addr[0] ? mem_dout[15:8] : mem_dout[7:0], and cpu_done set; cpu_wait falls the cycle after mem_ack.
- Video accesses are always reads (mem_we=0) with mem_bank=0.
- Watchdog: counts cycles in BUSY and resets on grant.
  - When the count reaches TIMEOUT without mem_ack: mem_req=0, err pulses, state IDLE.
  - The aborted requester is not acknowledged. Video and CPU re-arbitrate. A loader entry stays buffered.
- mem_ack while in IDLE is ignored.
- reset_n low mid-grant drops mem_req immediately (async) and discards the buffer.

Test Plan:
- Reset mid-grant: CPU read granted, reset_n low 3 cycles into BUSY -> mem_req=0 immediately, ldr_busy=0, cpu_wait follows cpu_rd; after release, re-arbitration issues the read again.
- Single CPU read: cpu_rd=1, addr 0x000101; mem_ack after 4 cycles with mem_dout=0xA55A -> cpu_dout=0xA5, cpu_wait low the cycle after ack; no second grant while cpu_rd stays high.
- Collision: vid_req, cpu_wr and ldr_wr in the same cycle -> grant order video, CPU, loader. mem_we is 0, 1, 1. ldr_busy stays high until the third ack.
- Starvation: loader buffer full, vid_req held permanently, ack 2 cycles after each req -> after 15 video grants the 16th grant goes to the loader; starve_cnt returns to 0.
- Overrun: two ldr_wr pulses 1 cycle apart with no ack -> second dropped, ldr_overrun=1, first byte written with original addr/data.
- Watchdog: grant issued, mem_ack withheld 63 cycles -> err pulse, mem_req=0, no vid_ack; a later mem_ack in IDLE produces no response.
